uart_transceiver: RTL

UART_TRANSCEIVER -- requirements
Module: uart_transceiver

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_fifo.sv | 50 +++++
 rtl/uart_transceiver.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and the parity-bit helper.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   // Bit that makes the total count of ones even (PARITY_EVEN) or odd (PARITY_ODD).
   function automatic logic parity_bit(input logic [7:0] data, input logic mode);
      return (^data) ^ (mode == PARITY_ODD);
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with combinational head (zero when empty); zero-latency read, one-cycle write.
// Push while full is accepted only together with a pop; otherwise it is ignored.
module uart_fifo #(
   parameter int Width = 8,
   parameter int Depth = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [Width-1:0] push_data,
   input  logic             pop,
   output logic [Width-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(Depth);

   logic [Width-1:0] mem [Depth];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             do_push, do_pop;

   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(Depth));
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = empty ? '0 : mem[rd_ptr];

   // Depth is a power of two, so the pointers wrap on their own overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART with TX/RX FIFOs; frame starts one clock after TX data is queued, RX bytes appear at the stop-bit sample.
// TX backpressure via tx_ready_o (FIFO full); a full RX FIFO drops the incoming byte and pulses rx_overrun_o.
module uart_transceiver #(
   parameter int DataBits  = 8,
   parameter int FifoDepth = 4,
   parameter int DivWidth  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DivWidth-1:0] baud_div_i,
   input  logic                parity_en_i,
   input  logic                parity_odd_i,
   input  logic [DataBits-1:0] tx_data_i,
   input  logic                tx_valid_i,
   output logic                tx_ready_o,
   output logic [DataBits-1:0] rx_data_o,
   output logic                rx_valid_o,
   input  logic                rx_ready_i,
   output logic                tx_o,
   input  logic                rx_i,
   output logic                tx_busy_o,
   output logic                rx_overrun_o,
   output logic                rx_parity_err_o,
   output logic                rx_frame_err_o
);
   import uart_pkg::*;

   localparam logic [2:0] LAST_BIT = 3'(DataBits - 1);

   logic                tx_fifo_full, tx_fifo_empty, tx_pop, tx_tick;
   logic [DataBits-1:0] tx_head, tx_shift;
   uart_state_t         tx_state;
   logic [DivWidth-1:0] tx_div, tx_cnt;
   logic [2:0]          tx_bit;
   logic                tx_par_en, tx_par;

   assign tx_ready_o = !tx_fifo_full;
   assign tx_tick    = (tx_cnt == tx_div);
   assign tx_pop     = !tx_fifo_empty && ((tx_state == IDLE) || (tx_state == STOP && tx_tick));
   assign tx_busy_o  = !tx_fifo_empty || (tx_state != IDLE);

   uart_fifo #(.Width(DataBits), .Depth(FifoDepth)) u_tx_fifo (
      .clk(clk), .rst(rst),
      .push(tx_valid_i && tx_ready_o), .push_data(tx_data_i),
      .pop(tx_pop), .pop_data(tx_head),
      .full(tx_fifo_full), .empty(tx_fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state  <= IDLE;
         tx_o      <= 1'b1;
         tx_cnt    <= '0;
         tx_div    <= '0;
         tx_bit    <= '0;
         tx_shift  <= '0;
         tx_par_en <= 1'b0;
         tx_par    <= 1'b0;
      end else if (tx_pop) begin
         // Covers both IDLE and STOP, so back-to-back frames have no idle gap.
         tx_state  <= START;
         tx_o      <= 1'b0;
         tx_cnt    <= '0;
         tx_div    <= baud_div_i;
         tx_shift  <= tx_head;
         tx_par_en <= parity_en_i;
         tx_par    <= parity_bit(8'(tx_head), parity_odd_i ? PARITY_ODD : PARITY_EVEN);
      end else if (tx_state != IDLE) begin
         if (!tx_tick) begin
            tx_cnt <= tx_cnt + DivWidth'(1);
         end else begin
            tx_cnt <= '0;
            case (tx_state)
               START: begin
                  tx_state <= DATA;
                  tx_o     <= tx_shift[0];
                  tx_bit   <= '0;
               end
               DATA: begin
                  if (tx_bit == LAST_BIT) begin
                     tx_state <= tx_par_en ? PARITY : STOP;
                     tx_o     <= tx_par_en ? tx_par : 1'b1;
                  end else begin
                     tx_bit   <= tx_bit + 3'd1;
                     tx_shift <= tx_shift >> 1;
                     tx_o     <= tx_shift[1];
                  end
               end
               PARITY: begin
                  tx_state <= STOP;
                  tx_o     <= 1'b1;
               end
               default: tx_state <= IDLE;
            endcase
         end
      end
   end

   logic [1:0]          rx_sync;
   logic                rx_s, rx_prev, rx_tick, rx_half, rx_stop_evt, rx_pop;
   logic                rx_fifo_full, rx_fifo_empty;
   uart_state_t         rx_state;
   logic [DivWidth-1:0] rx_div, rx_cnt;
   logic [DivWidth:0]   half_m1;
   logic [2:0]          rx_bit;
   logic [DataBits-1:0] rx_shift;
   logic                rx_par_en, rx_mode, rx_par_bad;

   assign rx_s        = rx_sync[1];
   assign half_m1     = (({1'b0, rx_div} + (DivWidth+1)'(1)) >> 1) - (DivWidth+1)'(1);
   assign rx_half     = ({1'b0, rx_cnt} == half_m1);
   assign rx_tick     = (rx_cnt == rx_div);
   assign rx_stop_evt = (rx_state == STOP) && rx_tick;
   assign rx_valid_o  = !rx_fifo_empty;
   assign rx_pop      = rx_valid_o && rx_ready_i;

   assign rx_overrun_o    = rx_stop_evt && rx_fifo_full && !rx_pop;
   assign rx_parity_err_o = rx_stop_evt && rx_par_bad;
   assign rx_frame_err_o  = rx_stop_evt && !rx_s;

   uart_fifo #(.Width(DataBits), .Depth(FifoDepth)) u_rx_fifo (
      .clk(clk), .rst(rst),
      .push(rx_stop_evt), .push_data(rx_shift),
      .pop(rx_pop), .pop_data(rx_data_o),
      .full(rx_fifo_full), .empty(rx_fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_sync    <= 2'b11;
         rx_prev    <= 1'b1;
         rx_state   <= IDLE;
         rx_cnt     <= '0;
         rx_div     <= '0;
         rx_bit     <= '0;
         rx_shift   <= '0;
         rx_par_en  <= 1'b0;
         rx_mode    <= PARITY_EVEN;
         rx_par_bad <= 1'b0;
      end else begin
         rx_sync <= {rx_sync[0], rx_i};
         rx_prev <= rx_s;
         case (rx_state)
            IDLE: begin
               if (rx_prev && !rx_s) begin
                  rx_state   <= START;
                  rx_cnt     <= '0;
                  rx_div     <= baud_div_i;
                  rx_par_en  <= parity_en_i;
                  rx_mode    <= parity_odd_i ? PARITY_ODD : PARITY_EVEN;
                  rx_par_bad <= 1'b0;
               end
            end
            START: begin
               // A start bit that is high again at mid-bit was a glitch.
               if (rx_half) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_s ? IDLE : DATA;
               end else begin
                  rx_cnt <= rx_cnt + DivWidth'(1);
               end
            end
            default: begin
               if (!rx_tick) begin
                  rx_cnt <= rx_cnt + DivWidth'(1);
               end else begin
                  rx_cnt <= '0;
                  case (rx_state)
                     DATA: begin
                        rx_shift <= {rx_s, rx_shift[DataBits-1:1]};
                        if (rx_bit == LAST_BIT) rx_state <= rx_par_en ? PARITY : STOP;
                        else                    rx_bit   <= rx_bit + 3'd1;
                     end
                     PARITY: begin
                        rx_par_bad <= (rx_s != parity_bit(8'(rx_shift), rx_mode));
                        rx_state   <= STOP;
                     end
                     default: rx_state <= IDLE;
                  endcase
               end
            end
         endcase
      end
   end

endmodule
